proc_mem_arbiter: RTL and testbench

// - Shares one single-ported memory between the pipelined TinyRV1 core's fetch (imem, port 0) and

---
 rtl/proc_mem_pkg.sv | 23 ++
 rtl/mem_arb_id_queue.sv | 59 +++++
 rtl/proc_mem_arbiter.sv | 101 ++++++++++
 tb/tb_proc_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_mem_pkg.sv
// Shared types and constants for the processor/memory arbiter.
// Request/response field widths and port identifiers.
package proc_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic MEM_REQ_READ  = 1'b0;
  localparam logic MEM_REQ_WRITE = 1'b1;

  localparam logic PORT_IMEM = 1'b0;
  localparam logic PORT_DMEM = 1'b1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic  typ;
    addr_t addr;
    data_t wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_id_queue.sv
// FIFO of 1-bit port IDs for in-flight memory requests.
// Head is read combinationally so responses route with no delay.
module mem_arb_id_queue
  import proc_mem_pkg::*;
#(
  parameter int unsigned p_depth = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  logic                           i_push_id,
  input  logic                           i_pop,
  output logic                           o_head,
  output logic [$clog2(p_depth+1)-1:0]   o_count,
  output logic                           o_full,
  output logic                           o_empty
);

  localparam int unsigned CW = $clog2(p_depth + 1);
  localparam int unsigned PW = (p_depth > 1) ? $clog2(p_depth) : 1;

  logic          r_mem [p_depth];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_count == CW'(p_depth));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_push_id;
        r_wr        <= nxt(r_wr);
      end
      if (w_pop)
        r_rd <= nxt(r_rd);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/proc_mem_arbiter.sv
// Round-robin sharing of one memory between fetch and data ports.
// Responses return in order to the port recorded at issue time.
module proc_mem_arbiter
  import proc_mem_pkg::*;
#(
  parameter int unsigned p_max_outst = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  input  logic        imemreq_type,
  input  logic [31:0] imemreq_addr,
  input  logic [31:0] imemreq_wdata,
  output logic        imemresp_val,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic        dmemresp_val,
  output logic [31:0] dmemresp_data,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  output logic        memreq_type,
  output logic [31:0] memreq_addr,
  output logic [31:0] memreq_wdata,
  input  logic        memresp_val,
  input  logic [31:0] memresp_data,
  output logic        resp_err
);

  localparam int unsigned CW = $clog2(p_max_outst + 1);

  logic          r_last_grant;
  logic          r_resp_err;
  logic          w_any;
  logic          w_gnt;
  logic          w_can_issue;
  logic          w_pop;
  logic          w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  mem_req_t      w_req;
  mem_req_t      w_ireq;
  mem_req_t      w_dreq;

  mem_arb_id_queue #(.p_depth(p_max_outst)) u_q (
    .clk       (clk),
    .rst       (rst),
    .i_push    (memreq_val),
    .i_push_id (w_gnt),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Issue depends only on the queue occupancy, never on memresp_val.
  assign w_can_issue = memreq_rdy & ~w_full & ~rst;
  assign w_any       = imemreq_val | dmemreq_val;
  assign w_gnt       = (imemreq_val & dmemreq_val) ? ~r_last_grant
                                                   : dmemreq_val;

  assign w_ireq = '{typ: imemreq_type, addr: imemreq_addr,
                    wdata: imemreq_wdata};
  assign w_dreq = '{typ: dmemreq_type, addr: dmemreq_addr,
                    wdata: dmemreq_wdata};
  assign w_req  = (!w_any || rst) ? '0
                : (w_gnt == PORT_DMEM) ? w_dreq : w_ireq;

  assign memreq_val   = w_can_issue & w_any;
  assign memreq_type  = w_req.typ;
  assign memreq_addr  = w_req.addr;
  assign memreq_wdata = w_req.wdata;
  assign imemreq_rdy  = w_can_issue & imemreq_val & (w_gnt == PORT_IMEM);
  assign dmemreq_rdy  = w_can_issue & dmemreq_val & (w_gnt == PORT_DMEM);

  assign w_pop         = memresp_val & ~w_empty & ~rst;
  assign imemresp_val  = w_pop & (w_head == PORT_IMEM);
  assign dmemresp_val  = w_pop & (w_head == PORT_DMEM);
  assign imemresp_data = imemresp_val ? memresp_data : '0;
  assign dmemresp_data = dmemresp_val ? memresp_data : '0;
  assign resp_err      = r_resp_err & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= PORT_DMEM;
      r_resp_err   <= 1'b0;
    end else begin
      if (memreq_val)
        r_last_grant <= w_gnt;
      if (memresp_val && w_empty)
        r_resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Bench for proc_mem_arbiter: directed scenarios plus random traffic
// checked against a queue-based model of the arbitration rules.
module tb_proc_mem_arbiter;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemreq_val, imemreq_rdy, imemreq_type;
  logic [31:0] imemreq_addr, imemreq_wdata;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        dmemreq_val, dmemreq_rdy, dmemreq_type;
  logic [31:0] dmemreq_addr, dmemreq_wdata;
  logic        dmemresp_val;
  logic [31:0] dmemresp_data;
  logic        memreq_val, memreq_rdy, memreq_type;
  logic [31:0] memreq_addr, memreq_wdata;
  logic        memresp_val;
  logic [31:0] memresp_data;
  logic        resp_err;

  int n_chk  = 0;
  int n_fail = 0;

  int q[$];
  int lastg = 1;
  bit err   = 0;

  logic o_mval, o_irdy, o_drdy, o_ival, o_dval, o_err;
  logic [31:0] o_idata, o_maddr;

  always #5 clk = ~clk;

  proc_mem_arbiter #(.p_max_outst(MAX)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemreq_type(imemreq_type), .imemreq_addr(imemreq_addr),
    .imemreq_wdata(imemreq_wdata),
    .imemresp_val(imemresp_val), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
    .dmemreq_wdata(dmemreq_wdata),
    .dmemresp_val(dmemresp_val), .dmemresp_data(dmemresp_data),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memreq_type(memreq_type), .memreq_addr(memreq_addr),
    .memreq_wdata(memreq_wdata),
    .memresp_val(memresp_val), .memresp_data(memresp_data),
    .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rnd_fields();
    imemreq_type  = 1'($urandom);
    imemreq_addr  = $urandom;
    imemreq_wdata = $urandom;
    dmemreq_type  = 1'($urandom);
    dmemreq_addr  = $urandom;
    dmemreq_wdata = $urandom;
  endtask

  task automatic step(input logic r, input logic iv, input logic dv,
                      input logic mr, input logic rv,
                      input logic [31:0] rd);
    int  sz;
    bit  can, any, win, pop, ev, eir, edr;
    logic [31:0] ea, ew;
    logic        et;
    rst = r; imemreq_val = iv; dmemreq_val = dv;
    memreq_rdy = mr; memresp_val = rv; memresp_data = rd;
    #2;
    sz  = q.size();
    can = mr && (sz < MAX) && !r;
    any = iv || dv;
    win = (iv && dv) ? (lastg == 0) : dv;
    ev  = can && any;
    eir = can && iv && !win;
    edr = can && dv && win;
    pop = rv && (sz > 0) && !r;
    chk("memreq_val", 32'(memreq_val), 32'(ev));
    chk("imemreq_rdy", 32'(imemreq_rdy), 32'(eir));
    chk("dmemreq_rdy", 32'(dmemreq_rdy), 32'(edr));
    if (ev) begin
      et = win ? dmemreq_type : imemreq_type;
      ea = win ? dmemreq_addr : imemreq_addr;
      ew = win ? dmemreq_wdata : imemreq_wdata;
      chk("memreq_type", 32'(memreq_type), 32'(et));
      chk("memreq_addr", memreq_addr, ea);
      chk("memreq_wdata", memreq_wdata, ew);
    end else if (!any || r) begin
      chk("memreq_addr_idle", memreq_addr, 32'h0);
      chk("memreq_wdata_idle", memreq_wdata, 32'h0);
    end
    chk("imemresp_val", 32'(imemresp_val), 32'(pop && q[0] == 0));
    chk("dmemresp_val", 32'(dmemresp_val), 32'(pop && q[0] == 1));
    if (pop && q[0] == 0) chk("imemresp_data", imemresp_data, rd);
    if (pop && q[0] == 1) chk("dmemresp_data", dmemresp_data, rd);
    chk("resp_err", 32'(resp_err), 32'(err && !r));
    o_mval = memreq_val; o_irdy = imemreq_rdy; o_drdy = dmemreq_rdy;
    o_ival = imemresp_val; o_dval = dmemresp_val; o_err = resp_err;
    o_idata = imemresp_data; o_maddr = memreq_addr;
    @(posedge clk);
    if (r) begin
      q.delete(); lastg = 1; err = 0;
    end else begin
      if (rv) begin
        if (sz > 0) void'(q.pop_front());
        else err = 1;
      end
      if (ev) begin
        q.push_back(int'(win));
        lastg = int'(win);
      end
    end
    #1;
  endtask

  initial begin
    rst = 1; memreq_rdy = 0; memresp_val = 0; memresp_data = 0;
    imemreq_val = 0; dmemreq_val = 0;
    rnd_fields();
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 32'h1234);
    chk("rst_mval", 32'(o_mval), 32'h0);

    // single imem read, then its response
    imemreq_type = 1'b0; imemreq_addr = 32'h100;
    step(0, 1, 0, 1, 0, 0);
    chk("t1_mval", 32'(o_mval), 32'h1);
    chk("t1_irdy", 32'(o_irdy), 32'h1);
    chk("t1_addr", o_maddr, 32'h100);
    step(0, 0, 0, 1, 1, 32'hDEADBEEF);
    chk("t1_ival", 32'(o_ival), 32'h1);
    chk("t1_idata", o_idata, 32'hDEADBEEF);
    chk("t1_dval", 32'(o_dval), 32'h0);

    // alternating grants from reset
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      rnd_fields();
      step(0, 1, 1, 1, k > 0, $urandom);
      chk("t2_irdy", 32'(o_irdy), 32'((k % 2) == 0));
      chk("t2_drdy", 32'(o_drdy), 32'((k % 2) == 1));
    end
    step(0, 0, 0, 1, 1, $urandom);
    chk("t2_last_dval", 32'(o_dval), 32'h1);

    // queue full blocks issue, pop does not free the same cycle
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      rnd_fields();
      step(0, 1, 1, 1, 0, 0);
    end
    chk("t3_full_mval", 32'(o_mval), 32'h0);
    chk("t3_full_irdy", 32'(o_irdy), 32'h0);
    chk("t3_full_drdy", 32'(o_drdy), 32'h0);
    step(0, 1, 1, 1, 1, $urandom);
    chk("t3_poppush_mval", 32'(o_mval), 32'h0);
    step(0, 1, 1, 1, 0, 0);
    chk("t3_next_mval", 32'(o_mval), 32'h1);

    // memory not ready
    while (q.size() > 0) step(0, 0, 0, 1, 1, $urandom);
    step(0, 1, 1, 0, 0, 0);
    chk("t4_mval", 32'(o_mval), 32'h0);
    step(0, 1, 1, 1, 0, 0);
    while (q.size() > 0) step(0, 0, 0, 1, 1, $urandom);

    // spurious response
    step(0, 0, 0, 1, 1, 32'h55);
    chk("t5_ival", 32'(o_ival), 32'h0);
    chk("t5_dval", 32'(o_dval), 32'h0);
    step(0, 0, 0, 1, 0, 0);
    chk("t5_err", 32'(o_err), 32'h1);
    step(0, 0, 0, 1, 0, 0);
    chk("t5_err_sticky", 32'(o_err), 32'h1);

    // reset mid-operation
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    rnd_fields();
    step(0, 0, 1, 1, 0, 0);
    chk("t6_err", 32'(o_err), 32'h0);
    chk("t6_drdy", 32'(o_drdy), 32'h1);
    chk("t6_mval", 32'(o_mval), 32'h1);

    // random traffic
    for (int k = 0; k < 500; k++) begin
      logic r, rv;
      rnd_fields();
      r  = ($urandom_range(0, 99) < 2);
      rv = (q.size() > 0) ? 1'($urandom) : ($urandom_range(0, 99) < 3);
      step(r, 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0, rv, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
